perceptron_mac_sequencer: RTL and testbench
===========================================

# perceptron_mac_sequencer

Sequences one perceptron dot product on the shared sign-magnitude fixed-point multiplier. It fetches weight/input pairs from two synchronous-read memories and streams them through the external multiplier. It accumulates the products with saturation on top of a bias and returns the pre-activation sum over a valid/ready handshake. It sits between the layer controller (start/result) and the `fixed_point_multiplier` instance, which it owns exclusively while busy.

## Interface
- `SIGN`, 1: sign bit count; fixed at 1, sign-magnitude (MSB = sign, rest = magnitude).
- `Q_M`, 16: integer magnitude bits.
- `Q_N`, 16: fractional magnitude bits.
- `MAX_INPUTS`, 16: maximum dot-product length.
- `MUL_LATENCY`, 1: clock cycles from multiplier operands to `mul_y_in` valid (≥1).
- W = SIGN+Q_M+Q_N; AW = $clog2(MAX_INPUTS).

Ports:
- `clk_i` in 1: clock, rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `start_in` in 1: start request, accepted only when `busy_out`=0 and `valid_out`=0.
- `n_inputs_in` in AW+1: dot-product length, sampled at accept; values >MAX_INPUTS clamp to MAX_INPUTS.
- `bias_in` in W: bias, sampled at accept.
- `busy_out` out 1: operation in progress.
- `mem_rd_out` out 1: read strobe to both memories.
- `mem_addr_out` out AW: shared weight/input address.
- `w_data_in`, `x_data_in` in W: memory read data, valid one cycle after `mem_rd_out`.
- `mul_a_out`, `mul_b_out` out W: multiplier operands.
- `mul_y_in` in W: multiplier product.
- `valid_out` out 1, `ready_in` in 1: result handshake.
- `y_out` out W: accumulated sum.
- `sat_out` out 1: at least one accumulation saturated this operation; qualified by `valid_out`.

## Operation
- States: IDLE → FETCH → DRAIN → DONE → IDLE.
- **IDLE**
  - On `start_in`, latch `bias_in` into the accumulator and the clamped count into N; clear `sat_out`.
  - Go to FETCH if N>0, else DONE.
- **FETCH**
  - Assert `mem_rd_out` with `mem_addr_out` = 0..N-1, one address per cycle.
  - After address N-1 is issued, go to DRAIN.
- **Multiplier feed**
  - `mul_a_out` = `w_data_in` and `mul_b_out` = `x_data_in`, passed through combinationally.
  - A `MUL_LATENCY+1`-deep valid shift register tags each issued read so its product can be identified.
- **DRAIN**
  - Wait until all N tagged products have been accumulated, then go to DONE.
- **DONE**
  - Hold `valid_out`=1 with `y_out` and `sat_out` stable until `ready_in`=1, then go to IDLE.
- **Accumulate** (sign-magnitude, accumulator A + product P):
  - Same signs: add magnitudes. On carry out, set magnitude to all ones, keep the sign, set `sat_out`.
  - Different signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - A zero magnitude always gets sign 0 (no negative zero).
- `busy_out`=1 in FETCH and DRAIN only.
- `start_in` is ignored while busy or in DONE; requests are not queued.
- `mul_a_out`/`mul_b_out` are don't-care while no tagged read is in flight, but they must not be X after reset.

## Timing
- Reset values: `busy_out`=0, `mem_rd_out`=0, `mem_addr_out`=0, `valid_out`=0, `y_out`=0, `sat_out`=0, state IDLE, accumulator 0, valid shift register 0.
- Let cycle 0 be the accept cycle.
  - Address i is issued in cycle i+1.
  - The operands for element i are valid in cycle i+2.
  - The product for element i is valid in cycle i+2+MUL_LATENCY and is accumulated at the end of that cycle.
- `valid_out` rises in cycle N+MUL_LATENCY+2; for N=0 it rises in cycle 1.
- Throughput: one multiply per cycle, with no bubbles during FETCH.
- If `ready_in`=1 in the first DONE cycle, `valid_out` is high for exactly one cycle. The earliest next accept is the cycle after the handshake.
- Asynchronous reset mid-operation: immediately return to IDLE with the reset values above. In-flight products are discarded, and the next `start_in` after deassertion behaves normally.

## Test plan
- 1 input, bias 0: w = x = 0.5 (0x0_0000_8000) → `y_out` = 0x0_0000_4000 (0.25), `valid_out` in cycle 4 with MUL_LATENCY=1, `sat_out`=0.
- 3 inputs with mixed signs: (−0.5·−0.5) + (1.5·1.5) + (−1.5·0.5), bias +1.0 → 0.25+2.25−0.75+1.0 = 2.75 = 0x0_0002_C000. Also check that `mem_addr_out` steps 0,1,2 on consecutive cycles.
- Cancellation: 0.5·0.5 and −0.5·0.5, bias 0 → `y_out` = 0x0_0000_0000, sign bit 0.
- Saturation: two products of 200.0·200.0 (each 40000 > 2^15), bias +40000 → magnitude all ones, sign 0, `sat_out`=1.
- N=0 with bias −3.0 → `valid_out` in cycle 1 with `y_out` = 0x1_0003_0000. Hold `ready_in`=0 for 5 cycles and confirm `y_out` is stable and a new `start_in` is ignored.
- Reset mid-FETCH (N=8, assert `reset_ni` low at cycle 4) → all outputs go to reset values asynchronously. A subsequent N=1 run returns the correct product.

Source files
------------

// File: rtl/perceptron_mac_sequencer.sv
// perceptron_mac_sequencer: fetches weight/input pairs, streams them through the
// shared sign-magnitude multiplier and accumulates a saturating dot product plus bias.
module perceptron_mac_sequencer #(
    parameter int SIGN        = 1,
    parameter int Q_M         = 16,
    parameter int Q_N         = 16,
    parameter int MAX_INPUTS  = 16,
    parameter int MUL_LATENCY = 1,
    parameter int W           = SIGN + Q_M + Q_N,
    parameter int AW          = $clog2(MAX_INPUTS)
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_in,
    input  logic [AW:0]   n_inputs_in,
    input  logic [W-1:0]  bias_in,
    output logic          busy_out,
    output logic          mem_rd_out,
    output logic [AW-1:0] mem_addr_out,
    input  logic [W-1:0]  w_data_in,
    input  logic [W-1:0]  x_data_in,
    output logic [W-1:0]  mul_a_out,
    output logic [W-1:0]  mul_b_out,
    input  logic [W-1:0]  mul_y_in,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [W-1:0]  y_out,
    output logic          sat_out
);
    localparam int M = W - 1;
    localparam logic [AW:0] N_MAX = (AW + 1)'(MAX_INPUTS);
    localparam logic [MUL_LATENCY:0] LAST_ONLY = (MUL_LATENCY + 1)'(1) << MUL_LATENCY;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW:0]            n_q, n_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [W-1:0]           acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [MUL_LATENCY:0]   vld_q, vld_d;

    logic [AW:0]            n_clamp;
    logic                   last_addr;
    logic [M:0]             sum;
    logic                   same_sign, acc_ge;
    logic [M-1:0]           mag;
    logic                   sgn, ovf;

    assign n_clamp   = (n_inputs_in > N_MAX) ? N_MAX : n_inputs_in;
    assign last_addr = ({1'b0, addr_q} + 1'b1) == n_q;

    // Sign-magnitude accumulate of the tagged product onto the accumulator
    always_comb begin
        sum       = {1'b0, acc_q[M-1:0]} + {1'b0, mul_y_in[M-1:0]};
        same_sign = acc_q[M] == mul_y_in[M];
        acc_ge    = acc_q[M-1:0] >= mul_y_in[M-1:0];
        mag       = same_sign ? (sum[M] ? '1 : sum[M-1:0])
                  : acc_ge    ? acc_q[M-1:0] - mul_y_in[M-1:0]
                  :             mul_y_in[M-1:0] - acc_q[M-1:0];
        sgn       = (mag != '0) && ((same_sign || acc_ge) ? acc_q[M] : mul_y_in[M]);
        ovf       = same_sign && sum[M];
    end

    // Next-state, address sequencing and accumulator update
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        vld_d   = {vld_q[MUL_LATENCY-1:0], state_q == FETCH};
        if (vld_q[MUL_LATENCY]) begin
            acc_d = {sgn, mag};
            sat_d = sat_q | ovf;
        end
        case (state_q)
            IDLE: if (start_in) begin
                acc_d   = bias_in;
                n_d     = n_clamp;
                sat_d   = 1'b0;
                addr_d  = '0;
                state_d = (n_clamp == '0) ? DONE : FETCH;
            end
            FETCH: begin
                addr_d  = last_addr ? '0 : addr_q + 1'b1;
                state_d = last_addr ? DRAIN : FETCH;
            end
            DRAIN:   state_d = (vld_q == LAST_ONLY) ? DONE : DRAIN;
            DONE:    state_d = ready_in ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            n_q     <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            vld_q   <= vld_d;
        end
    end

    assign busy_out     = (state_q == FETCH) || (state_q == DRAIN);
    assign mem_rd_out   = state_q == FETCH;
    assign mem_addr_out = addr_q;
    assign mul_a_out    = vld_q[0] ? w_data_in : '0;
    assign mul_b_out    = vld_q[0] ? x_data_in : '0;
    assign valid_out    = state_q == DONE;
    assign y_out        = acc_q;
    assign sat_out      = sat_q;
endmodule

// File: tb/tb_perceptron_mac_sequencer.sv
// tb_perceptron_mac_sequencer: directed vectors with a scoreboard-driven result monitor.
module tb_perceptron_mac_sequencer;
    localparam logic [32:0] P05  = 33'h0_0000_8000;
    localparam logic [32:0] N05  = 33'h1_0000_8000;
    localparam logic [32:0] P15  = 33'h0_0001_8000;
    localparam logic [32:0] N15  = 33'h1_0001_8000;
    localparam logic [32:0] P10  = 33'h0_0001_0000;
    localparam logic [32:0] P200 = 33'h0_00C8_0000;
    localparam logic [32:0] P40K = 33'h0_9C40_0000;
    localparam logic [32:0] N30  = 33'h1_0003_0000;
    localparam logic [32:0] P50  = 33'h0_0005_0000;

    typedef struct {
        logic [32:0] y;
        logic        sat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start_in;
    logic [4:0]  n_inputs_in;
    logic [32:0] bias_in;
    logic        busy_out, mem_rd_out, valid_out, ready_in, sat_out;
    logic [3:0]  mem_addr_out;
    logic [32:0] w_data_in, x_data_in, mul_a_out, mul_b_out, mul_y_in, y_out;

    logic [32:0] wmem [16];
    logic [32:0] xmem [16];
    exp_t        sb [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          prev_v = 1'b0;

    perceptron_mac_sequencer dut (
        .clk_i(clk), .reset_ni(reset_ni), .start_in(start_in), .n_inputs_in(n_inputs_in),
        .bias_in(bias_in), .busy_out(busy_out), .mem_rd_out(mem_rd_out),
        .mem_addr_out(mem_addr_out), .w_data_in(w_data_in), .x_data_in(x_data_in),
        .mul_a_out(mul_a_out), .mul_b_out(mul_b_out), .mul_y_in(mul_y_in),
        .valid_out(valid_out), .ready_in(ready_in), .y_out(y_out), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] smul(input logic [32:0] a, input logic [32:0] b);
        logic [63:0] p;
        logic [31:0] m;
        p = 64'(a[31:0]) * 64'(b[31:0]);
        m = p[47:16];
        return {(m != 32'd0) && (a[32] ^ b[32]), m};
    endfunction

    // synchronous-read memories and a one-cycle multiplier model
    always @(posedge clk) begin
        if (mem_rd_out) begin
            w_data_in <= wmem[mem_addr_out];
            x_data_in <= xmem[mem_addr_out];
        end
        mul_y_in <= smul(mul_a_out, mul_b_out);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // result monitor: compares every cycle valid_out is high against the scoreboard head
    always @(negedge clk) begin
        if (!reset_ni) prev_v = 1'b0;
        else begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got y=%h with no result expected", y_out);
                end else begin
                    if (!prev_v) chk("valid_cycle", 64'(cyc), 64'(sb[0].cyc));
                    chk("y_out", 64'(y_out), 64'(sb[0].y));
                    chk("sat_out", 64'(sat_out), 64'(sb[0].sat));
                    if (ready_in) sb.delete(0);
                end
            end
            prev_v = valid_out;
        end
    end

    task automatic run(input int n, input logic [32:0] bias, input logic [32:0] ey,
                       input logic es, input bit expect_it);
        int ev;
        ev = (n == 0) ? cyc + 1 : cyc + ((n > 16) ? 16 : n) + 3;
        if (expect_it) sb.push_back('{y: ey, sat: es, cyc: ev});
        n_inputs_in = 5'(n);
        bias_in     = bias;
        start_in    = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1 chk("result_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd_out), 64'd0);
        chk("rst_addr", 64'(mem_addr_out), 64'd0);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_y", 64'(y_out), 64'd0);
        chk("rst_sat", 64'(sat_out), 64'd0);
        chk("rst_mul_a_known", 64'($isunknown(mul_a_out)), 64'd0);
    endtask

    initial begin
        reset_ni = 1'b0;
        start_in = 1'b0;
        ready_in = 1'b1;
        n_inputs_in = '0;
        bias_in = '0;
        w_data_in = '0;
        x_data_in = '0;
        mul_y_in = '0;
        for (int i = 0; i < 16; i++) begin
            wmem[i] = '0;
            xmem[i] = '0;
        end
        #3 check_reset_outputs();
        #9 reset_ni = 1'b1;
        @(posedge clk);
        #1;

        wmem[0] = P05; xmem[0] = P05;
        run(1, '0, 33'h0_0000_4000, 1'b0, 1'b1);
        wait_empty();

        wmem[0] = N05; xmem[0] = N05;
        wmem[1] = P15; xmem[1] = P15;
        wmem[2] = N15; xmem[2] = P05;
        run(3, P10, 33'h0_0002_C000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fetch_rd", 64'(mem_rd_out), 64'd1);
            chk("fetch_addr", 64'(mem_addr_out), 64'(i));
        end
        wait_empty();

        wmem[0] = P200; xmem[0] = P200;
        wmem[1] = P200; xmem[1] = P200;
        run(2, P40K, 33'h0_FFFF_FFFF, 1'b1, 1'b1);
        wait_empty();

        wmem[0] = P05; xmem[0] = P05;
        wmem[1] = N05; xmem[1] = P05;
        run(2, '0, 33'h0_0000_0000, 1'b0, 1'b1);
        wait_empty();

        for (int i = 0; i < 16; i++) begin
            wmem[i] = P10;
            xmem[i] = P10;
        end
        run(20, '0, 33'h0_0010_0000, 1'b0, 1'b1);
        wait_empty();

        ready_in = 1'b0;
        run(0, N30, N30, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 n_inputs_in = 5'd1;
        start_in = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
        @(negedge clk);
        chk("done_ignores_start_busy", 64'(busy_out), 64'd0);
        chk("done_holds_valid", 64'(valid_out), 64'd1);
        repeat (2) @(posedge clk);
        #1 ready_in = 1'b1;
        wait_empty();
        @(negedge clk);
        chk("idle_after_handshake", 64'({busy_out, valid_out}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            wmem[i] = P05;
            xmem[i] = P05;
        end
        run(8, P50, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_ni = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 reset_ni = 1'b1;
        @(posedge clk);
        #1 wmem[0] = P15; xmem[0] = N05;
        run(1, '0, 33'h1_0000_C000, 1'b0, 1'b1);
        wait_empty();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
